// File: rtl/id_bypass_scoreboard.sv
// id_bypass_scoreboard: ID-stage bypass selector and load-use stall generator.
// Every in-flight register writer is tracked through a DEPTH-stage shadow
// pipeline (index 0 = EXE, DEPTH-1 = WB). Each entry also records the first
// stage whose result bus carries its value. Each read port forwards from the
// youngest matching writer, or requests a stall when that writer is not yet
// ready.
// Optional feature: define ID_BYPASS_STALL_CNT_EN to get a saturating 32-bit
// stall-cycle counter on stall_cnt. Without the macro, stall_cnt is tied to 0.
module id_bypass_scoreboard #(
    parameter int NUM_RD = 2,
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int AREG_W = 5,
    parameter int STG_W  = $clog2(DEPTH),
    parameter int SEL_W  = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pipe_adv,
    input  logic                     issue_valid,
    input  logic                     issue_we,
    input  logic [AREG_W-1:0]        issue_dst,
    input  logic [STG_W-1:0]         issue_rdy_stg,
    input  logic [DEPTH-1:0]         flush_mask,
    input  logic [DEPTH*DATA_W-1:0]  stage_result,
    input  logic [NUM_RD*AREG_W-1:0] rd_addr,
    input  logic [NUM_RD-1:0]        rd_used,
    input  logic [NUM_RD*DATA_W-1:0] rf_rdata,
    output logic [NUM_RD*DATA_W-1:0] fwd_data,
    output logic [NUM_RD*SEL_W-1:0]  fwd_sel,
    output logic                     stall,
    output logic [31:0]              stall_cnt
);

    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [DEPTH-1:0]  we_q, we_d;
    logic [AREG_W-1:0] dst_q [DEPTH];
    logic [AREG_W-1:0] dst_d [DEPTH];
    logic [STG_W-1:0]  rdy_q [DEPTH];
    logic [STG_W-1:0]  rdy_d [DEPTH];
    logic [DEPTH-1:0]  stg_ready;

    // Next shadow-pipeline state. Flushes act on the pre-shift positions, then the shift happens, then the issue slot fills.
    always_comb begin
        valid_d = valid_q & ~flush_mask;
        we_d    = we_q;
        dst_d   = dst_q;
        rdy_d   = rdy_q;
        if (pipe_adv) begin
            for (int s = DEPTH - 1; s > 0; s--) begin
                valid_d[s] = valid_q[s-1] & ~flush_mask[s-1];
                we_d[s]    = we_q[s-1];
                dst_d[s]   = dst_q[s-1];
                rdy_d[s]   = rdy_q[s-1];
            end
            valid_d[0] = issue_valid;
            we_d[0]    = issue_we && (issue_dst != '0);
            dst_d[0]   = issue_dst;
            rdy_d[0]   = issue_rdy_stg;
        end
    end

    // Shadow-pipeline registers. Only the valid bits need reset because the payload is ignored when valid is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
        we_q  <= we_d;
        dst_q <= dst_d;
        rdy_q <= rdy_d;
    end

    // A stage can supply its entry's value once the entry has reached its result-ready stage.
    always_comb begin
        stg_ready = '0;
        for (int s = 0; s < DEPTH; s++) begin
            stg_ready[s] = (32'(rdy_q[s]) <= 32'(s));
        end
    end

    // Per-port lookup. The scan runs from oldest to youngest so the youngest matching writer ends up selected.
    always_comb begin
        logic              hit;
        logic              hit_ready;
        logic [SEL_W-1:0]  hit_sel;
        logic [DATA_W-1:0] hit_data;
        logic [AREG_W-1:0] addr;
        fwd_data = rf_rdata;
        fwd_sel  = '0;
        stall    = 1'b0;
        for (int p = 0; p < NUM_RD; p++) begin
            hit       = 1'b0;
            hit_ready = 1'b0;
            hit_sel   = '0;
            hit_data  = '0;
            addr      = rd_addr[p*AREG_W +: AREG_W];
            for (int s = DEPTH - 1; s >= 0; s--) begin
                if (valid_q[s] && we_q[s] && (dst_q[s] == addr) && (addr != '0)) begin
                    hit       = 1'b1;
                    hit_ready = stg_ready[s];
                    hit_sel   = SEL_W'(s + 1);
                    hit_data  = stage_result[s*DATA_W +: DATA_W];
                end
            end
            if (hit && hit_ready) begin
                fwd_sel[p*SEL_W +: SEL_W]    = hit_sel;
                fwd_data[p*DATA_W +: DATA_W] = hit_data;
            end
            if (rd_used[p] && hit && !hit_ready) begin
                stall = 1'b1;
            end
        end
    end

`ifdef ID_BYPASS_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // The count saturates at all-ones rather than wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

    // Issuing while the back end is frozen would lose the instruction.
    a_issue_needs_adv: assert property (@(posedge clk) disable iff (rst)
        !(issue_valid && !pipe_adv));

    // The result-ready stage must name a tracked stage.
    a_rdy_stg_legal: assert property (@(posedge clk) disable iff (rst)
        (issue_valid && pipe_adv) |-> (32'(issue_rdy_stg) < 32'(DEPTH)));

endmodule

// File: tb/tb_id_bypass_scoreboard.sv
// tb_id_bypass_scoreboard: directed scenarios and a randomized run. The
// randomized run is checked against a model of in-flight instructions.
module tb_id_bypass_scoreboard;

    localparam int NUM_RD = 2;
    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int AREG_W = 5;
    localparam int STG_W  = 2;
    localparam int SEL_W  = 3;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     pipe_adv;
    logic                     issue_valid;
    logic                     issue_we;
    logic [AREG_W-1:0]        issue_dst;
    logic [STG_W-1:0]         issue_rdy_stg;
    logic [DEPTH-1:0]         flush_mask;
    logic [DEPTH*DATA_W-1:0]  stage_result;
    logic [NUM_RD*AREG_W-1:0] rd_addr;
    logic [NUM_RD-1:0]        rd_used;
    logic [NUM_RD*DATA_W-1:0] rf_rdata;
    logic [NUM_RD*DATA_W-1:0] fwd_data;
    logic [NUM_RD*SEL_W-1:0]  fwd_sel;
    logic                     stall;
    logic [31:0]              stall_cnt;

    logic [AREG_W-1:0] ra [NUM_RD];
    logic [DATA_W-1:0] rf [NUM_RD];
    logic [DATA_W-1:0] sr [DEPTH];

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit v;
        bit we;
        int dst;
        int rdy;
    } ment_t;

    ment_t m [DEPTH];
`ifdef ID_BYPASS_STALL_CNT_EN
    logic [31:0] mcnt;
`endif

    id_bypass_scoreboard #(
        .NUM_RD(NUM_RD), .DEPTH(DEPTH), .DATA_W(DATA_W), .AREG_W(AREG_W),
        .STG_W(STG_W), .SEL_W(SEL_W)
    ) dut (
        .clk(clk), .rst(rst), .pipe_adv(pipe_adv), .issue_valid(issue_valid),
        .issue_we(issue_we), .issue_dst(issue_dst), .issue_rdy_stg(issue_rdy_stg),
        .flush_mask(flush_mask), .stage_result(stage_result), .rd_addr(rd_addr),
        .rd_used(rd_used), .rf_rdata(rf_rdata), .fwd_data(fwd_data),
        .fwd_sel(fwd_sel), .stall(stall), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    always_comb begin
        rd_addr      = '0;
        rf_rdata     = '0;
        stage_result = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            rd_addr[p*AREG_W +: AREG_W]  = ra[p];
            rf_rdata[p*DATA_W +: DATA_W] = rf[p];
        end
        for (int s = 0; s < DEPTH; s++) begin
            stage_result[s*DATA_W +: DATA_W] = sr[s];
        end
    end

    function automatic int get_sel(int p);
        return int'(fwd_sel[p*SEL_W +: SEL_W]);
    endfunction

    function automatic logic [DATA_W-1:0] get_data(int p);
        return fwd_data[p*DATA_W +: DATA_W];
    endfunction

    // Youngest matching in-flight writer decides; it forwards only once it has reached its ready stage.
    function automatic void model_lookup(input int p, output int sel,
                                         output logic [DATA_W-1:0] data, output bit pend);
        sel  = 0;
        data = rf[p];
        pend = 1'b0;
        for (int s = 0; s < DEPTH; s++) begin
            if (m[s].v && m[s].we && m[s].dst == int'(ra[p]) && ra[p] != 0) begin
                if (s >= m[s].rdy) begin
                    sel  = s + 1;
                    data = sr[s];
                end else begin
                    pend = 1'b1;
                end
                break;
            end
        end
    endfunction

    function automatic bit model_stall();
        int sel;
        logic [DATA_W-1:0] data;
        bit pend;
        bit st = 1'b0;
        for (int p = 0; p < NUM_RD; p++) begin
            model_lookup(p, sel, data, pend);
            if (rd_used[p] && pend) st = 1'b1;
        end
        return st;
    endfunction

    function automatic logic [31:0] model_cnt();
`ifdef ID_BYPASS_STALL_CNT_EN
        return mcnt;
`else
        return 32'd0;
`endif
    endfunction

    // Advance the model with the current inputs, then let the DUT take the same clock edge.
    task automatic tick();
        bit st = model_stall();
`ifdef ID_BYPASS_STALL_CNT_EN
        if (rst) mcnt = 32'd0;
        else if (st && mcnt != 32'hFFFF_FFFF) mcnt = mcnt + 32'd1;
`endif
        if (st) begin end
        if (rst) begin
            for (int s = 0; s < DEPTH; s++) m[s].v = 1'b0;
        end else begin
            for (int s = 0; s < DEPTH; s++) if (flush_mask[s]) m[s].v = 1'b0;
            if (pipe_adv) begin
                for (int s = DEPTH - 1; s > 0; s--) m[s] = m[s-1];
                m[0] = '{issue_valid, issue_we && issue_dst != 0, int'(issue_dst), int'(issue_rdy_stg)};
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pipe_adv      = 1'b0;
        issue_valid   = 1'b0;
        issue_we      = 1'b0;
        issue_dst     = '0;
        issue_rdy_stg = '0;
        flush_mask    = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic issue_op(input int dst, input int rdy);
        pipe_adv      = 1'b1;
        issue_valid   = 1'b1;
        issue_we      = 1'b1;
        issue_dst     = AREG_W'(dst);
        issue_rdy_stg = STG_W'(rdy);
        tick();
        idle();
    endtask

    task automatic bubble();
        pipe_adv    = 1'b1;
        issue_valid = 1'b0;
        tick();
        pipe_adv    = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        ra[0] = 5; ra[1] = 3; rd_used = 2'b11;
        rf[0] = 32'hAAAA_0001; rf[1] = 32'hBBBB_0002;
        #1;
        total++; if (get_sel(0) !== 0 || get_sel(1) !== 0) begin bad++;
            $display("[TB] FAIL reset_sel got=%0d,%0d exp=0,0", get_sel(0), get_sel(1)); end
        total++; if (get_data(0) !== 32'hAAAA_0001 || get_data(1) !== 32'hBBBB_0002) begin bad++;
            $display("[TB] FAIL reset_data got=%h,%h exp=aaaa0001,bbbb0002", get_data(0), get_data(1)); end
        total++; if (stall !== 1'b0) begin bad++;
            $display("[TB] FAIL reset_stall got=%b exp=0", stall); end
        total++; if (stall_cnt !== 32'd0) begin bad++;
            $display("[TB] FAIL reset_cnt got=%0d exp=0", stall_cnt); end
    endtask

    task automatic test_alu_forward();
        do_reset();
        issue_op(5, 0);
        ra[0] = 5; ra[1] = 3; rd_used = 2'b11; sr[0] = 32'h1234; sr[3] = 32'h5555_AAAA;
        #1;
        total++; if (get_sel(0) !== 1 || get_data(0) !== 32'h1234) begin bad++;
            $display("[TB] FAIL alu_exe got sel=%0d data=%h exp sel=1 data=1234", get_sel(0), get_data(0)); end
        total++; if (stall !== 1'b0) begin bad++;
            $display("[TB] FAIL alu_stall got=%b exp=0", stall); end
        for (int i = 0; i < 3; i++) bubble();
        #1;
        total++; if (get_sel(0) !== 4 || get_data(0) !== 32'h5555_AAAA) begin bad++;
            $display("[TB] FAIL alu_wb got sel=%0d data=%h exp sel=4 data=5555aaaa", get_sel(0), get_data(0)); end
        bubble();
        #1;
        total++; if (get_sel(0) !== 0 || get_data(0) !== rf[0]) begin bad++;
            $display("[TB] FAIL alu_retired got sel=%0d data=%h exp sel=0 data=%h", get_sel(0), get_data(0), rf[0]); end
    endtask

    task automatic test_load_use();
        do_reset();
        issue_op(7, 2);
        ra[0] = 7; ra[1] = 0; rd_used = 2'b01; sr[2] = 32'hCAFE_F00D;
        #1;
        total++; if (stall !== 1'b1) begin bad++;
            $display("[TB] FAIL load_stall_exe got=%b exp=1", stall); end
        bubble();
        #1;
        total++; if (stall !== 1'b1) begin bad++;
            $display("[TB] FAIL load_stall_mem got=%b exp=1", stall); end
        bubble();
        #1;
        total++; if (stall !== 1'b0 || get_sel(0) !== 3 || get_data(0) !== 32'hCAFE_F00D) begin bad++;
            $display("[TB] FAIL load_fwd got stall=%b sel=%0d data=%h exp stall=0 sel=3 data=cafef00d",
                     stall, get_sel(0), get_data(0)); end
    endtask

    task automatic test_youngest_wins();
        do_reset();
        issue_op(9, 0);
        bubble();
        issue_op(9, 0);
        bubble();
        ra[0] = 9; ra[1] = 3; rd_used = 2'b01; sr[1] = 32'h0000_000A; sr[3] = 32'h0000_000B;
        #1;
        total++; if (get_sel(0) !== 2 || get_data(0) !== 32'h0000_000A) begin bad++;
            $display("[TB] FAIL youngest_alu got sel=%0d data=%h exp sel=2 data=0000000a", get_sel(0), get_data(0)); end
        issue_op(9, 2);
        #1;
        total++; if (stall !== 1'b1 || get_sel(0) !== 0) begin bad++;
            $display("[TB] FAIL youngest_load got stall=%b sel=%0d exp stall=1 sel=0", stall, get_sel(0)); end
    endtask

    task automatic test_flush_unused_r0();
        do_reset();
        issue_op(4, 2);
        bubble();
        ra[0] = 4; ra[1] = 0; rd_used = 2'b01;
        flush_mask = 4'b0010;
        #1;
        total++; if (stall !== 1'b1) begin bad++;
            $display("[TB] FAIL flush_preflush got=%b exp=1", stall); end
        tick();
        flush_mask = '0;
        #1;
        total++; if (stall !== 1'b0 || get_sel(0) !== 0) begin bad++;
            $display("[TB] FAIL flush_after got stall=%b sel=%0d exp stall=0 sel=0", stall, get_sel(0)); end
        issue_op(4, 2);
        rd_used = 2'b00;
        #1;
        total++; if (stall !== 1'b0) begin bad++;
            $display("[TB] FAIL unused_port got=%b exp=0", stall); end
        do_reset();
        issue_op(0, 0);
        ra[0] = 0; rd_used = 2'b01; rf[0] = 32'h0BAD_0000;
        #1;
        total++; if (get_sel(0) !== 0 || get_data(0) !== 32'h0BAD_0000) begin bad++;
            $display("[TB] FAIL r0_writer got sel=%0d data=%h exp sel=0 data=0bad0000", get_sel(0), get_data(0)); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        issue_op(6, 0);
        ra[0] = 6; rd_used = 2'b01;
        pipe_adv = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0; pipe_adv = 1'b0;
        #1;
        total++; if (get_sel(0) !== 0) begin bad++;
            $display("[TB] FAIL reset_mid got sel=%0d exp=0", get_sel(0)); end
    endtask

    task automatic test_stall_cnt();
`ifdef ID_BYPASS_STALL_CNT_EN
        do_reset();
        issue_op(7, 3);
        ra[0] = 7; rd_used = 2'b01;
        for (int i = 0; i < 5; i++) tick();
        #1;
        total++; if (stall_cnt !== 32'd5) begin bad++;
            $display("[TB] FAIL stall_cnt_five got=%0d exp=5", stall_cnt); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        total++; if (stall_cnt !== 32'd0) begin bad++;
            $display("[TB] FAIL stall_cnt_reset got=%0d exp=0", stall_cnt); end
`endif
    endtask

    task automatic test_random();
        int sel;
        logic [DATA_W-1:0] data;
        bit pend;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            rst           = ($urandom_range(0, 79) == 0);
            pipe_adv      = ($urandom_range(0, 3) != 0);
            issue_valid   = pipe_adv && ($urandom_range(0, 3) != 0);
            issue_we      = ($urandom_range(0, 9) != 0);
            issue_dst     = AREG_W'($urandom_range(0, 7));
            issue_rdy_stg = STG_W'($urandom_range(0, 3));
            flush_mask    = ($urandom_range(0, 7) == 0) ? DEPTH'($urandom) : '0;
            rd_used       = NUM_RD'($urandom);
            for (int p = 0; p < NUM_RD; p++) begin
                ra[p] = AREG_W'($urandom_range(0, 7));
                rf[p] = $urandom;
            end
            for (int s = 0; s < DEPTH; s++) sr[s] = $urandom;
            #1;
            for (int p = 0; p < NUM_RD; p++) begin
                model_lookup(p, sel, data, pend);
                total++; if (get_sel(p) !== sel || get_data(p) !== data) begin bad++;
                    $display("[TB] FAIL rand_fwd cyc=%0d port=%0d got sel=%0d data=%h exp sel=%0d data=%h",
                             cyc, p, get_sel(p), get_data(p), sel, data); end
            end
            total++; if (stall !== model_stall()) begin bad++;
                $display("[TB] FAIL rand_stall cyc=%0d got=%b exp=%b", cyc, stall, model_stall()); end
            total++; if (stall_cnt !== model_cnt()) begin bad++;
                $display("[TB] FAIL rand_cnt cyc=%0d got=%0d exp=%0d", cyc, stall_cnt, model_cnt()); end
            tick();
        end
        rst = 1'b0;
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        rd_used = '0;
        for (int p = 0; p < NUM_RD; p++) begin ra[p] = '0; rf[p] = '0; end
        for (int s = 0; s < DEPTH; s++) begin sr[s] = '0; m[s] = '{1'b0, 1'b0, 0, 0}; end
`ifdef ID_BYPASS_STALL_CNT_EN
        mcnt = 32'd0;
`endif
        @(posedge clk);
        #1;
        test_reset();
        test_alu_forward();
        test_load_use();
        test_youngest_wins();
        test_flush_unused_r0();
        test_reset_mid();
        test_stall_cnt();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
